// File: rtl/kna6034201_deser.sv
// kna6034201_deser: serial-to-parallel bitplane packer.
// Captures up to four serial bitplane streams at the pixel clock-enable rate,
// packs each 8-pixel group into planar bytes and presents them on a
// valid/ready output with a sticky overflow flag for dropped groups.
// Optional feature macro: KNA6034201_DESER_TRANSP_EN adds out_transp, which is
// high when every pixel of the presented group has plane index zero.
module kna6034201_deser #(
  parameter int PLANES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       CE_PIXEL,
  input  logic       START,
  input  logic       FLIP,
  input  logic       bit_1,
  input  logic       bit_2,
  input  logic       bit_3,
  input  logic       bit_4,
  output logic [7:0] byte_1,
  output logic [7:0] byte_2,
  output logic [7:0] byte_3,
  output logic [7:0] byte_4,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       group_flip
`ifdef KNA6034201_DESER_TRANSP_EN
  ,
  output logic       out_transp
`endif
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             flip_q, flip_d;
  logic [3:0][7:0]  sr_q, sr_d;
  logic [3:0][7:0]  obyte_q, obyte_d;
  logic             vld_q, vld_d;
  logic             ov_q, ov_d;
  logic             gflip_q, gflip_d;
`ifdef KNA6034201_DESER_TRANSP_EN
  logic             transp_q, transp_d;
`endif

  logic [3:0]       bits;
  logic [3:0][7:0]  shifted;
  logic [3:0][7:0]  packed_bytes;
  logic             capture;
  logic             cur_flip;
  logic [2:0]       pos;
  logic             complete;
  logic             load;
  logic             drop;

  assign bits = {bit_4, bit_3, bit_2, bit_1};

  // Next-state computation: pixel capture, group completion and output handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flip_d   = flip_q;
    sr_d     = sr_q;
    obyte_d  = obyte_q;
    vld_d    = vld_q;
    gflip_d  = gflip_q;
`ifdef KNA6034201_DESER_TRANSP_EN
    transp_d = transp_q;
`endif

    // START always restarts a group (even in COLLECT) and re-latches FLIP.
    capture  = CE_PIXEL && (START || (state_q == COLLECT));
    cur_flip = START ? FLIP : flip_q;
    pos      = START ? 3'd0 : cnt_q;

    // The shifted value includes the current pixel, so a completing group
    // can be loaded into the output register on this very edge.
    for (int p = 0; p < 4; p++) begin
      shifted[p]      = cur_flip ? {bits[p], sr_q[p][7:1]} : {sr_q[p][6:0], bits[p]};
      packed_bytes[p] = (p < PLANES) ? shifted[p] : 8'h00;
    end

    complete = capture && (pos == 3'd7);
    load     = complete && (!vld_q || out_ready);
    drop     = complete && !load;

    if (capture) begin
      state_d = COLLECT;
      flip_d  = cur_flip;
      sr_d    = shifted;
      cnt_d   = pos + 3'd1;
    end

    if (load) begin
      obyte_d  = packed_bytes;
      vld_d    = 1'b1;
      gflip_d  = cur_flip;
`ifdef KNA6034201_DESER_TRANSP_EN
      transp_d = (packed_bytes == '0);
`endif
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ov_d = 1'b1;
    end else if (clr_overflow) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      flip_q   <= 1'b0;
      sr_q     <= '0;
      obyte_q  <= '0;
      vld_q    <= 1'b0;
      ov_q     <= 1'b0;
      gflip_q  <= 1'b0;
`ifdef KNA6034201_DESER_TRANSP_EN
      transp_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flip_q   <= flip_d;
      sr_q     <= sr_d;
      obyte_q  <= obyte_d;
      vld_q    <= vld_d;
      ov_q     <= ov_d;
      gflip_q  <= gflip_d;
`ifdef KNA6034201_DESER_TRANSP_EN
      transp_q <= transp_d;
`endif
    end
  end

  assign byte_1     = obyte_q[0];
  assign byte_2     = obyte_q[1];
  assign byte_3     = obyte_q[2];
  assign byte_4     = obyte_q[3];
  assign out_valid  = vld_q;
  assign overflow   = ov_q;
  assign group_flip = gflip_q;
`ifdef KNA6034201_DESER_TRANSP_EN
  assign out_transp = transp_q;
`endif

endmodule

// File: tb/tb_kna6034201_deser.sv
// Testbench for kna6034201_deser: scoreboard of expected groups checked at
// each accepted output, plus scenario tasks with inline checks.
module tb_kna6034201_deser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       CE_PIXEL = 1'b0;
  logic       START = 1'b0;
  logic       FLIP = 1'b0;
  logic       bit_1 = 1'b0, bit_2 = 1'b0, bit_3 = 1'b0, bit_4 = 1'b0;
  logic [7:0] byte_1, byte_2, byte_3, byte_4;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       group_flip;
`ifdef KNA6034201_DESER_TRANSP_EN
  logic       out_transp;
`endif

  int chk_total = 0;
  int chk_pass  = 0;
  int acc_cnt   = 0;
  bit mon_en    = 1'b0;
  logic [32:0] exp_q[$];   // {flip, byte_4, byte_3, byte_2, byte_1}

  kna6034201_deser #(.PLANES(4)) dut (
    .clock(clock), .reset(reset), .CE_PIXEL(CE_PIXEL), .START(START), .FLIP(FLIP),
    .bit_1(bit_1), .bit_2(bit_2), .bit_3(bit_3), .bit_4(bit_4),
    .byte_1(byte_1), .byte_2(byte_2), .byte_3(byte_3), .byte_4(byte_4),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .clr_overflow(clr_overflow), .group_flip(group_flip)
`ifdef KNA6034201_DESER_TRANSP_EN
    , .out_transp(out_transp)
`endif
  );

  always #5 clock = ~clock;

  // Scoreboard: every accepted group must match the oldest expected entry.
  always @(negedge clock) begin
    if (mon_en && out_valid && out_ready) begin
      logic [32:0] e;
      acc_cnt++;
      chk_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %h_%h_%h_%h flip=%b, required no output",
                 byte_4, byte_3, byte_2, byte_1, group_flip);
      end else begin
        e = exp_q.pop_front();
        if ({group_flip, byte_4, byte_3, byte_2, byte_1} !== e)
          $display("FAIL sb_group: got %h, required %h",
                   {group_flip, byte_4, byte_3, byte_2, byte_1}, e);
        else
          chk_pass++;
`ifdef KNA6034201_DESER_TRANSP_EN
        chk_total++;
        if (out_transp !== (e[31:0] == 32'h0))
          $display("FAIL sb_transp: got %b, required %b", out_transp, (e[31:0] == 32'h0));
        else
          chk_pass++;
`endif
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // One pixel on a CE_PIXEL cycle, preceded by gap-1 idle cycles.
  task automatic pix(input logic st, input logic fl, input logic [3:0] b, input int gap);
    for (int g = 1; g < gap; g++) begin
      CE_PIXEL = 1'b0; START = 1'b0;
      @(posedge clock); #1;
    end
    CE_PIXEL = 1'b1; START = st; FLIP = fl;
    {bit_4, bit_3, bit_2, bit_1} = b;
    @(posedge clock); #1;
    CE_PIXEL = 1'b0; START = 1'b0;
  endtask

  // Drive a group whose packed result is v = {byte_4,byte_3,byte_2,byte_1}.
  // flip=0: pixel i is bit 7-i of each byte; flip=1: pixel i is bit i.
  task automatic send_group(input logic st, input logic fl, input logic [31:0] v,
                            input int gap, input bit push);
    logic [3:0] b;
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 4; p++)
        b[p] = fl ? v[8*p + i] : v[8*p + 7 - i];
      if (i == 7 && push) exp_q.push_back({fl, v});
      pix(st && (i == 0), fl, b, gap);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(3);
    @(negedge clock);
    chk_total++;
    if ({out_valid, overflow, group_flip, byte_4, byte_3, byte_2, byte_1} !== 35'h0)
      $display("FAIL reset_values: got v=%b ov=%b gf=%b bytes=%h%h%h%h, required all 0",
               out_valid, overflow, group_flip, byte_4, byte_3, byte_2, byte_1);
    else chk_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    // Pixels without START in IDLE are ignored.
    send_group(1'b0, 1'b0, 32'hFFFF_FFFF, 1, 1'b0);
    cycles(2);
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b0) $display("FAIL idle_ignore: got out_valid=%b, required 0", out_valid);
    else chk_pass++;
  endtask

  task automatic test_basic(input logic fl, input logic [7:0] expb);
    out_ready = 1'b1;
    mon_en = 1'b1;
    send_group(1'b1, fl, {24'h0, expb}, 1, 1'b1);
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b1 || byte_1 !== expb || group_flip !== fl)
      $display("FAIL basic_latency_flip%0b: got v=%b b1=%h gf=%b, required v=1 b1=%h gf=%b",
               fl, out_valid, byte_1, group_flip, expb, fl);
    else chk_pass++;
    @(posedge clock); #1;
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_pulse_flip%0b: got out_valid=%b, required 0", fl, out_valid);
    else chk_pass++;
  endtask

  task automatic test_overflow;
    mon_en = 1'b0;
    out_ready = 1'b0;
    send_group(1'b1, 1'b0, 32'hFFFF_FFFF, 1, 1'b0);
    send_group(1'b0, 1'b0, 32'h0000_0000, 1, 1'b0);
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b1 || overflow !== 1'b1 || {byte_4, byte_3, byte_2, byte_1} !== 32'hFFFF_FFFF)
      $display("FAIL ovf_hold: got v=%b ov=%b bytes=%h%h%h%h, required v=1 ov=1 bytes=ffffffff",
               out_valid, overflow, byte_4, byte_3, byte_2, byte_1);
    else chk_pass++;
    @(posedge clock); #1;
    clr_overflow = 1'b1;
    @(posedge clock); #1;
    clr_overflow = 1'b0;
    @(negedge clock);
    chk_total++;
    if (overflow !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL ovf_clear: got ov=%b v=%b, required ov=0 v=1", overflow, out_valid);
    else chk_pass++;
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b0 || byte_1 !== 8'hFF)
      $display("FAIL ovf_drain: got v=%b b1=%h, required v=0 b1=ff", out_valid, byte_1);
    else chk_pass++;
  endtask

  task automatic test_restart;
    int acc0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    acc0 = acc_cnt;
    for (int i = 0; i < 5; i++) pix(i == 0, 1'b0, 4'b0001, 1);
    send_group(1'b1, 1'b0, 32'h0000_FF00, 1, 1'b1);
    cycles(3);
    @(negedge clock);
    chk_total++;
    if (acc_cnt - acc0 != 1 || overflow !== 1'b0 || exp_q.size() != 0)
      $display("FAIL restart: got groups=%0d ov=%b pending=%0d, required groups=1 ov=0 pending=0",
               acc_cnt - acc0, overflow, exp_q.size());
    else chk_pass++;
  endtask

  task automatic test_ce_gap;
    int acc0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    acc0 = acc_cnt;
    send_group(1'b1, 1'b0, 32'hA5C3_0F81, 4, 1'b1);
    send_group(1'b0, 1'b0, 32'h1234_5678, 4, 1'b1);
    send_group(1'b0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1);
    cycles(3);
    @(negedge clock);
    chk_total++;
    if (acc_cnt - acc0 != 3 || overflow !== 1'b0 || exp_q.size() != 0)
      $display("FAIL ce_gap: got groups=%0d ov=%b pending=%0d, required groups=3 ov=0 pending=0",
               acc_cnt - acc0, overflow, exp_q.size());
    else chk_pass++;
  endtask

  task automatic test_mid_reset;
    int seen;
    mon_en = 1'b0;
    out_ready = 1'b0;
    send_group(1'b1, 1'b1, 32'h1234_5678, 1, 1'b0);
    for (int i = 0; i < 3; i++) pix(i == 0, 1'b0, 4'b1111, 1);
    @(negedge clock);
    chk_total++;
    if (out_valid !== 1'b1 || group_flip !== 1'b1)
      $display("FAIL pre_reset: got v=%b gf=%b, required v=1 gf=1", out_valid, group_flip);
    else chk_pass++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_total++;
    if ({out_valid, overflow, group_flip, byte_4, byte_3, byte_2, byte_1} !== 35'h0)
      $display("FAIL mid_reset: got v=%b ov=%b gf=%b bytes=%h%h%h%h, required all 0",
               out_valid, overflow, group_flip, byte_4, byte_3, byte_2, byte_1);
    else chk_pass++;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      pix(1'b0, 1'b0, 4'b1111, 1);
      if (out_valid !== 1'b0) seen++;
    end
    chk_total++;
    if (seen != 0) $display("FAIL post_reset_ignore: got %0d valid cycles, required 0", seen);
    else chk_pass++;
    mon_en = 1'b1;
    send_group(1'b1, 1'b1, 32'h0081_7E00, 1, 1'b1);
    cycles(3);
    @(negedge clock);
    chk_total++;
    if (exp_q.size() != 0)
      $display("FAIL post_reset_group: got pending=%0d, required 0", exp_q.size());
    else chk_pass++;
  endtask

  initial begin
    test_reset;
    test_basic(1'b0, 8'hB1);
    test_basic(1'b1, 8'h8D);
    test_overflow;
    test_restart;
    test_ce_gap;
    test_mid_reset;
    cycles(2);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
